id_ex_pipe_stage: RTL and testbench

ID_EX_PIPE_STAGE -- requirements
Module: id_ex_pipe_stage

---
 rtl/id_ex_pipe_stage.sv | 194 +++++++++++++++++++
 tb/tb_id_ex_pipe_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_stage
// Purpose  : Decode-to-execute pipeline register with valid/ready handshake.
//            SKID=1 builds a two-entry skid buffer whose id_ready_o comes
//            straight from a flop, which breaks the ready timing path back
//            into decode. SKID=0 builds a single register whose ready is
//            derived combinationally from the downstream ready.
// Ports    :
//   clk_i          rising-edge clock
//   rst_i          synchronous, active-high reset (priority over flush_i)
//   flush_i        drop every held and incoming entry this cycle
//   id_valid_i     decode presents an instruction
//   id_ready_o     stage can accept an instruction this cycle
//   rd_addr_i      destination register address   [REG_AW-1:0]
//   rs1_data_i     operand 1                      [DATA_W-1:0]
//   rs2_data_i     operand 2                      [DATA_W-1:0]
//   alu_op_i       ALU operation                  [OP_W-1:0]
//   ex_valid_o     EX-side payload valid
//   ex_ready_i     EX accepts the payload this cycle
//   rd_addr_ex_o   registered destination address
//   rs1_data_ex_o  registered operand 1
//   rs2_data_ex_o  registered operand 2
//   alu_op_ex_o    registered ALU operation
//   occupancy_o    number of held entries (0..2, at most 1 when SKID=0)
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 4,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [OP_W-1:0]   alu_op_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [REG_AW-1:0] rd_addr_ex_o,
    output logic [DATA_W-1:0] rs1_data_ex_o,
    output logic [DATA_W-1:0] rs2_data_ex_o,
    output logic [OP_W-1:0]   alu_op_ex_o,
    output logic [1:0]        occupancy_o
);

    // Whole payload travels as one vector so the storage logic stays compact.
    localparam int c_PAY_W = REG_AW + OP_W + 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    logic [c_PAY_W-1:0] w_pay_in;
    logic [c_PAY_W-1:0] w_pay_out;
    logic               w_ex_valid;
    logic               w_ready;
    logic [1:0]         w_occ;

    assign w_pay_in = {rd_addr_i, alu_op_i, rs2_data_i, rs1_data_i};

    assign {rd_addr_ex_o, alu_op_ex_o, rs2_data_ex_o, rs1_data_ex_o} = w_pay_out;
    assign ex_valid_o  = w_ex_valid;
    assign id_ready_o  = w_ready;
    assign occupancy_o = w_occ;

    generate
        if (SKID != 0) begin : g_skid
            state_t             r_state;
            state_t             w_state_nxt;
            logic               r_ready;
            logic [c_PAY_W-1:0] r_main;
            logic [c_PAY_W-1:0] r_skid;
            logic               w_accept;
            logic               w_xfer;
            logic               w_ld_main_in;
            logic               w_ld_main_skid;
            logic               w_ld_skid_in;

            assign w_ex_valid = (r_state != ST_EMPTY);
            assign w_accept   = id_valid_i && r_ready;
            assign w_xfer     = w_ex_valid && ex_ready_i;

            always_comb begin
                w_state_nxt    = r_state;
                w_ld_main_in   = 1'b0;
                w_ld_main_skid = 1'b0;
                w_ld_skid_in   = 1'b0;
                if (flush_i) begin
                    // Flush wins over both handshakes; nothing is loaded.
                    w_state_nxt = ST_EMPTY;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_accept) begin
                                w_state_nxt  = ST_ONE;
                                w_ld_main_in = 1'b1;
                            end
                        end
                        ST_ONE: begin
                            if (w_accept && w_xfer) begin
                                w_ld_main_in = 1'b1;
                            end else if (w_accept) begin
                                w_state_nxt  = ST_TWO;
                                w_ld_skid_in = 1'b1;
                            end else if (w_xfer) begin
                                w_state_nxt = ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            // Ready is low here, so only a drain can happen.
                            if (w_xfer) begin
                                w_state_nxt    = ST_ONE;
                                w_ld_main_skid = 1'b1;
                            end
                        end
                        default: begin
                            w_state_nxt = ST_EMPTY;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_state <= ST_EMPTY;
                    r_ready <= 1'b0;
                    r_main  <= '0;
                    r_skid  <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    // Ready for next cycle is a pure function of next state,
                    // so it can be registered without losing throughput.
                    r_ready <= (w_state_nxt != ST_TWO);
                    if (w_ld_main_in) begin
                        r_main <= w_pay_in;
                    end else if (w_ld_main_skid) begin
                        r_main <= r_skid;
                    end
                    if (w_ld_skid_in) begin
                        r_skid <= w_pay_in;
                    end
                end
            end

            assign w_ready   = r_ready;
            assign w_pay_out = r_main;
            assign w_occ     = (r_state == ST_TWO) ? 2'd2 :
                               (r_state == ST_ONE) ? 2'd1 : 2'd0;
        end else begin : g_single
            logic               r_valid;
            logic               r_init;
            logic [c_PAY_W-1:0] r_main;
            logic               w_accept;

            // r_init keeps ready low during reset and releases it one edge
            // after reset drops, matching the skid variant's behaviour.
            assign w_ready    = r_init && (!r_valid || ex_ready_i);
            assign w_accept   = id_valid_i && w_ready;
            assign w_ex_valid = r_valid;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_valid <= 1'b0;
                    r_init  <= 1'b0;
                    r_main  <= '0;
                end else begin
                    r_init <= 1'b1;
                    if (flush_i) begin
                        r_valid <= 1'b0;
                    end else if (w_accept) begin
                        // Covers accept-with-transfer: entry replaced in place.
                        r_valid <= 1'b1;
                        r_main  <= w_pay_in;
                    end else if (r_valid && ex_ready_i) begin
                        r_valid <= 1'b0;
                    end
                end
            end

            assign w_pay_out = r_main;
            assign w_occ     = {1'b0, r_valid};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe_stage
// Purpose  : Self-checking bench for id_ex_pipe_stage. One instance with the
//            skid buffer gets directed vectors; a second, single-register
//            instance is driven with random handshakes against a model.
//            Inputs are driven and outputs sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Skid instance signals
    logic        rst, flush, vld, rdy, exv, exr;
    logic [4:0]  rd, rd_x;
    logic [31:0] rs1, rs2, rs1_x, rs2_x;
    logic [3:0]  op, op_x;
    logic [1:0]  occ;

    // Single-register instance signals
    logic        rst0, flush0, vld0, rdy0, exv0, exr0;
    logic [4:0]  rd0, rd_x0;
    logic [31:0] rs1_0, rs2_0, rs1_x0, rs2_x0;
    logic [3:0]  op0, op_x0;
    logic [1:0]  occ0;

    int n_chk  = 0;
    int n_fail = 0;

    id_ex_pipe_stage #(.DATA_W(32), .REG_AW(5), .OP_W(4), .SKID(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .id_valid_i(vld), .id_ready_o(rdy),
        .rd_addr_i(rd), .rs1_data_i(rs1), .rs2_data_i(rs2), .alu_op_i(op),
        .ex_valid_o(exv), .ex_ready_i(exr),
        .rd_addr_ex_o(rd_x), .rs1_data_ex_o(rs1_x), .rs2_data_ex_o(rs2_x),
        .alu_op_ex_o(op_x), .occupancy_o(occ)
    );

    id_ex_pipe_stage #(.DATA_W(32), .REG_AW(5), .OP_W(4), .SKID(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst0), .flush_i(flush0),
        .id_valid_i(vld0), .id_ready_o(rdy0),
        .rd_addr_i(rd0), .rs1_data_i(rs1_0), .rs2_data_i(rs2_0), .alu_op_i(op0),
        .ex_valid_o(exv0), .ex_ready_i(exr0),
        .rd_addr_ex_o(rd_x0), .rs1_data_ex_o(rs1_x0), .rs2_data_ex_o(rs2_x0),
        .alu_op_ex_o(op_x0), .occupancy_o(occ0)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic put(input logic [4:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [3:0] d);
        vld = 1'b1; rd = a; rs1 = b; rs2 = c; op = d;
    endtask

    // Model of the single-register variant
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_acc, m_xfer;
    int          n_xfer0;

    initial begin
        rst = 1'b1; flush = 1'b0; vld = 1'b0; exr = 1'b0;
        rd = '0; rs1 = '0; rs2 = '0; op = '0;
        rst0 = 1'b1; flush0 = 1'b0; vld0 = 1'b0; exr0 = 1'b0;
        rd0 = '0; rs1_0 = '0; rs2_0 = '0; op0 = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_exv", 32'(exv), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_rs1", rs1_x, 32'd0);
        chk("rst_rd",  32'(rd_x), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 32'(rdy), 32'd1);
        chk("post_rst_exv", 32'(exv), 32'd0);

        // ---------------- single pass ----------------
        put(5'd5, 32'h11, 32'h22, 4'd3); exr = 1'b1;
        @(negedge clk);
        chk("sp_exv", 32'(exv), 32'd1);
        chk("sp_rd",  32'(rd_x), 32'd5);
        chk("sp_rs1", rs1_x, 32'h11);
        chk("sp_rs2", rs2_x, 32'h22);
        chk("sp_op",  32'(op_x), 32'd3);
        chk("sp_occ", 32'(occ), 32'd1);
        vld = 1'b0; rs1 = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("sp_exv_after", 32'(exv), 32'd0);
        chk("sp_occ_after", 32'(occ), 32'd0);
        chk("sp_hold_rs1",  rs1_x, 32'h11);

        // ---------------- back-pressure A,B,C ----------------
        exr = 1'b0;
        put(5'd1, 32'hA1, 32'hA2, 4'd1);
        @(negedge clk);
        chk("bp_occ1", 32'(occ), 32'd1);
        chk("bp_rs1_A", rs1_x, 32'hA1);
        put(5'd2, 32'hB1, 32'hB2, 4'd2);
        @(negedge clk);
        chk("bp_occ2", 32'(occ), 32'd2);
        chk("bp_rdy0", 32'(rdy), 32'd0);
        chk("bp_stable_A", rs1_x, 32'hA1);
        put(5'd3, 32'hC1, 32'hC2, 4'd4);
        @(negedge clk);
        chk("bp_occ2_hold", 32'(occ), 32'd2);
        chk("bp_rdy0_hold", 32'(rdy), 32'd0);
        chk("bp_stable_A2", rs1_x, 32'hA1);
        chk("bp_stable_rdA", 32'(rd_x), 32'd1);
        exr = 1'b1;
        @(negedge clk);
        chk("bp_out_B", rs1_x, 32'hB1);
        chk("bp_out_B_rs2", rs2_x, 32'hB2);
        chk("bp_occ_B", 32'(occ), 32'd1);
        chk("bp_rdy_B", 32'(rdy), 32'd1);
        @(negedge clk);
        chk("bp_out_C", rs1_x, 32'hC1);
        chk("bp_out_C_op", 32'(op_x), 32'd4);
        chk("bp_exv_C", 32'(exv), 32'd1);
        chk("bp_occ_C", 32'(occ), 32'd1);
        vld = 1'b0;
        @(negedge clk);
        chk("bp_exv_end", 32'(exv), 32'd0);
        chk("bp_occ_end", 32'(occ), 32'd0);

        // ---------------- full throughput ----------------
        exr = 1'b1;
        for (int i = 0; i < 100; i++) begin
            chk("ft_rdy_in", 32'(rdy), 32'd1);
            put(5'(i), 32'h100 + 32'(i), 32'h0, 4'd0);
            @(negedge clk);
            chk("ft_exv", 32'(exv), 32'd1);
            chk("ft_rs1", rs1_x, 32'h100 + 32'(i));
        end
        vld = 1'b0;
        @(negedge clk);
        chk("ft_exv_end", 32'(exv), 32'd0);

        // ---------------- flush in TWO with concurrent D ----------------
        exr = 1'b0;
        put(5'd7, 32'hA7, 32'h0, 4'd1);
        @(negedge clk);
        put(5'd8, 32'hB8, 32'h0, 4'd2);
        @(negedge clk);
        chk("fl_occ2", 32'(occ), 32'd2);
        put(5'd9, 32'hD9, 32'h0, 4'd5); flush = 1'b1;
        @(negedge clk);
        chk("fl_exv", 32'(exv), 32'd0);
        chk("fl_occ", 32'(occ), 32'd0);
        chk("fl_rdy", 32'(rdy), 32'd1);
        chk("fl_hold_rs1", rs1_x, 32'hA7);
        flush = 1'b0; vld = 1'b0; exr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fl_no_D", 32'(exv), 32'd0);
        end

        // flush in ONE while an accept is possible: the accept is discarded
        exr = 1'b0;
        put(5'd10, 32'hAA, 32'h0, 4'd1);
        @(negedge clk);
        put(5'd11, 32'hDD, 32'h0, 4'd1); flush = 1'b1;
        @(negedge clk);
        chk("fl1_exv", 32'(exv), 32'd0);
        chk("fl1_occ", 32'(occ), 32'd0);
        flush = 1'b0; vld = 1'b0; exr = 1'b1;
        @(negedge clk);
        chk("fl1_no_D", 32'(exv), 32'd0);

        // ---------------- reset in TWO ----------------
        exr = 1'b0;
        put(5'd12, 32'h55, 32'h66, 4'd7);
        @(negedge clk);
        put(5'd13, 32'h77, 32'h88, 4'd6);
        @(negedge clk);
        chk("rt_occ2", 32'(occ), 32'd2);
        vld = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rt_exv", 32'(exv), 32'd0);
        chk("rt_occ", 32'(occ), 32'd0);
        chk("rt_rdy", 32'(rdy), 32'd0);
        chk("rt_rs1", rs1_x, 32'd0);
        chk("rt_rs2", rs2_x, 32'd0);
        chk("rt_rd",  32'(rd_x), 32'd0);
        chk("rt_op",  32'(op_x), 32'd0);
        rst = 1'b0; exr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rt_no_emerge", 32'(exv), 32'd0);
        end
        chk("rt_rdy_back", 32'(rdy), 32'd1);

        // ---------------- single-register variant, random ----------------
        chk("s0_rst_rdy", 32'(rdy0), 32'd0);
        chk("s0_rst_exv", 32'(exv0), 32'd0);
        rst0 = 1'b0;
        m_valid = 1'b0; m_data = '0; n_xfer0 = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            chk("s0_exv", 32'(exv0), 32'(m_valid));
            if (m_valid) chk("s0_rs1", rs1_x0, m_data);
            vld0  = 1'($urandom_range(0, 1));
            exr0  = 1'($urandom_range(0, 1));
            rs1_0 = $urandom;
            rs2_0 = $urandom;
            #1;
            // first cycle after reset release: ready now expected high
            chk("s0_rdy_model", 32'(rdy0), 32'(!m_valid || exr0));
            chk("s0_rdy_form",  32'(rdy0), 32'(!exv0 || exr0));
            m_xfer = m_valid && exr0;
            m_acc  = vld0 && (!m_valid || exr0);
            if (m_xfer) n_xfer0++;
            if (m_acc) begin
                m_valid = 1'b1;
                m_data  = rs1_0;
            end else if (m_xfer) begin
                m_valid = 1'b0;
            end
        end
        chk("s0_some_xfers", 32'(n_xfer0 > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
